// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: condition codes, branch/cmov evaluation, hazard stall/bubble
// generation and ret/halt sequencing. Optional counters enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [3:0]  E_dstM,
  input  logic        e_zf,
  input  logic        e_sf,
  input  logic        e_of,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        e_cnd,
  output logic [2:0]  cc,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_luse,
  output logic [31:0] perf_mispred,
  output logic [31:0] perf_ret,
`endif
  output logic        halted
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_RET1 = 2'd1;
  localparam logic [1:0] S_RET2 = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;

  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  logic [1:0] state, next_state;
  logic       zf, sf, of;
  logic       cond;
  logic       load_use, mispred, ret_d;
  logic       m_bad, w_bad;
  logic       cc_wr;

  assign {zf, sf, of} = cc;

  // NOTE: every signal written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    cond = 1'b0;
    case (E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = (sf ^ of) | zf;
      4'h2:    cond = sf ^ of;
      4'h3:    cond = zf;
      4'h4:    cond = ~zf;
      4'h5:    cond = ~(sf ^ of);
      4'h6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  assign e_cnd = ((E_icode == I_CMOV) || (E_icode == I_JXX)) && cond;

  assign load_use = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                    ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispred  = (E_icode == I_JXX) && !e_cnd;
  assign ret_d    = (D_icode == I_RET) && (state == S_RUN);
  assign m_bad    = (m_stat != STAT_AOK);
  assign w_bad    = (W_stat != STAT_AOK);

  always_comb begin
    next_state = state;
    F_stall    = 1'b0;
    D_stall    = 1'b0;
    D_bubble   = 1'b0;
    E_bubble   = 1'b0;
    M_bubble   = 1'b0;
    W_stall    = 1'b0;
    case (state)
      S_RUN: begin
        if (load_use) begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
        end else if (mispred) begin
          D_bubble = 1'b1;
          E_bubble = 1'b1;
        end else if (ret_d) begin
          F_stall    = 1'b1;
          D_bubble   = 1'b1;
          next_state = S_RET1;
        end
      end
      S_RET1, S_RET2: begin
        // D only holds bubbles here, but the hazard terms stay OR'd in for safety.
        F_stall    = 1'b1;
        D_bubble   = 1'b1;
        D_stall    = load_use;
        E_bubble   = load_use | mispred;
        next_state = (state == S_RET1) ? S_RET2 : S_RUN;
      end
      default: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        W_stall  = 1'b1;
      end
    endcase
    if (m_bad) M_bubble = 1'b1;
    if (w_bad) begin
      W_stall    = 1'b1;
      next_state = S_HALT;
    end
    if (reset) begin
      next_state = S_RUN;
      F_stall    = 1'b0;
      D_stall    = 1'b0;
      D_bubble   = 1'b0;
      E_bubble   = 1'b0;
      M_bubble   = 1'b0;
      W_stall    = 1'b0;
    end
  end

  // An excepting instruction downstream must not let an OPq commit its flags.
  assign cc_wr = (E_icode == I_OPQ) && !m_bad && !w_bad && (state != S_HALT);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      cc    <= 3'b100;
    end else begin
      state <= next_state;
      if (cc_wr) cc <= {e_zf, e_sf, e_of};
    end
  end

  assign halted = (state == S_HALT);

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_luse    <= 32'd0;
      perf_mispred <= 32'd0;
      perf_ret     <= 32'd0;
    end else if (state != S_HALT) begin
      if (load_use) perf_luse <= perf_luse + 32'd1;
      if (mispred)  perf_mispred <= perf_mispred + 32'd1;
      if ((state == S_RUN) && (next_state == S_RET1)) perf_ret <= perf_ret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; perf counters checked when PIPE_CTRL_PERF_EN is set.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_ifun, E_dstM;
  logic       e_zf, e_sf, e_of;
  logic [2:0] m_stat, W_stat;
  logic       e_cnd;
  logic [2:0] cc;
  logic       F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_luse, perf_mispred, perf_ret;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
  logic [5:0] ctl;
  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110100;
  localparam logic [5:0] C_MISP = 6'b001100;
  localparam logic [5:0] C_RET  = 6'b101000;
  localparam logic [5:0] C_MEXC = 6'b000010;
  localparam logic [5:0] C_WEXC = 6'b000001;
  localparam logic [5:0] C_HALT = 6'b110111;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_ifun(E_ifun), .E_dstM(E_dstM),
    .e_zf(e_zf), .e_sf(e_sf), .e_of(e_of),
    .m_stat(m_stat), .W_stat(W_stat),
    .e_cnd(e_cnd), .cc(cc),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
`ifdef PIPE_CTRL_PERF_EN
    .perf_luse(perf_luse), .perf_mispred(perf_mispred), .perf_ret(perf_ret),
`endif
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nop_all();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_ifun = 4'h0; E_dstM = 4'hF;
    e_zf = 1'b0; e_sf = 1'b0; e_of = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    nop_all();
    tick();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9; W_stat = 3'd2;
    #1 chk("ctl_in_reset", 32'(ctl), 32'(C_NONE));
    chk("cc_in_reset", 32'(cc), 32'h4);
    nop_all();
    tick();
    reset = 1'b0;
    #1 chk("ctl_after_reset", 32'(ctl), 32'(C_NONE));
    chk("cc_after_reset", 32'(cc), 32'h4);
    chk("halted_after_reset", 32'(halted), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_luse_reset", perf_luse, 32'd0);
`endif

    // Conditions with cc = ZF only.
    E_icode = 4'h7; E_ifun = 4'h3; #1 chk("jeq_zf", 32'(e_cnd), 32'h1);
    E_ifun = 4'h1;                 #1 chk("jle_zf", 32'(e_cnd), 32'h1);
    E_ifun = 4'h4;                 #1 chk("jne_zf", 32'(e_cnd), 32'h0);
    chk("jne_mispred_ctl", 32'(ctl), 32'(C_MISP));
    E_icode = 4'h2; E_ifun = 4'h0; #1 chk("rrmov_always", 32'(e_cnd), 32'h1);
    E_icode = 4'h1;                #1 chk("nop_no_cnd", 32'(e_cnd), 32'h0);

    // Load/use detection.
    nop_all();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1 chk("luse_srcA", 32'(ctl), 32'(C_LU));
    E_icode = 4'hB; d_srcA = 4'hF; d_srcB = 4'h3; #1 chk("luse_popq_srcB", 32'(ctl), 32'(C_LU));
    E_icode = 4'h5; d_srcB = 4'h4;                #1 chk("luse_none", 32'(ctl), 32'(C_NONE));
    E_dstM = 4'hF; d_srcA = 4'hF;                 #1 chk("luse_rnone", 32'(ctl), 32'(C_NONE));

    // Set cc via OPq: ZF=0 SF=1 OF=0.
    nop_all();
    E_icode = 4'h6; e_sf = 1'b1;
    tick();
    chk("cc_set_opq", 32'(cc), 32'h2);
    nop_all();
    E_icode = 4'h7; E_ifun = 4'h3; #1 chk("je_cnd", 32'(e_cnd), 32'h0);
    chk("je_mispred", 32'(ctl), 32'(C_MISP));
    E_ifun = 4'h2; #1 chk("jl_cnd", 32'(e_cnd), 32'h1);
    chk("jl_no_bubble", 32'(ctl), 32'(C_NONE));
    E_ifun = 4'h6; #1 chk("jg_cnd", 32'(e_cnd), 32'h0);
    E_ifun = 4'h8; #1 chk("ifun8_cnd", 32'(e_cnd), 32'h0);
    E_icode = 4'h1; e_zf = 1'b1;
    tick();
    chk("cc_hold_non_opq", 32'(cc), 32'h2);

    // Ret: three cycles of F_stall/D_bubble.
    nop_all();
    D_icode = 4'h9; #1 chk("ret_d", 32'(ctl), 32'(C_RET));
    tick(); D_icode = 4'h1; #1 chk("ret1", 32'(ctl), 32'(C_RET));
    tick(); chk("ret2", 32'(ctl), 32'(C_RET));
    tick(); chk("ret_done", 32'(ctl), 32'(C_NONE));

    // Ret delayed by a coincident load/use.
    D_icode = 4'h9; E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    #1 chk("ret_luse", 32'(ctl), 32'(C_LU));
    tick(); nop_all(); D_icode = 4'h9;
    #1 chk("ret_late_d", 32'(ctl), 32'(C_RET));
    tick(); D_icode = 4'h1; #1 chk("ret_late_1", 32'(ctl), 32'(C_RET));
    tick(); chk("ret_late_2", 32'(ctl), 32'(C_RET));
    tick(); chk("ret_late_done", 32'(ctl), 32'(C_NONE));

    // Memory-stage exception suppresses CC write.
    E_icode = 4'h6; e_zf = 1'b1; e_of = 1'b1; m_stat = 3'd3;
    #1 chk("m_exc_ctl", 32'(ctl), 32'(C_MEXC));
    tick();
    chk("m_exc_cc", 32'(cc), 32'h2);

    // Writeback halt.
    m_stat = 3'd1; W_stat = 3'd2;
    #1 chk("w_exc_ctl", 32'(ctl), 32'(C_WEXC));
    chk("w_exc_not_halted", 32'(halted), 32'h0);
    tick();
    chk("halted_set", 32'(halted), 32'h1);
    chk("halt_ctl", 32'(ctl), 32'(C_HALT));
    chk("halt_cc", 32'(cc), 32'h2);
    nop_all(); E_icode = 4'h6; e_sf = 1'b1; e_of = 1'b1; D_icode = 4'h9;
    tick(); tick();
    chk("halt_sticky", 32'(halted), 32'h1);
    chk("halt_sticky_ctl", 32'(ctl), 32'(C_HALT));
    chk("halt_cc_frozen", 32'(cc), 32'h2);
    reset = 1'b1;
    #1 chk("halt_reset_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    chk("halt_reset_halted", 32'(halted), 32'h0);
    chk("halt_reset_cc", 32'(cc), 32'h4);
    nop_all();
    reset = 1'b0;
    #1 chk("post_reset_ctl", 32'(ctl), 32'(C_NONE));

`ifdef PIPE_CTRL_PERF_EN
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    tick(); tick();
    nop_all(); E_icode = 4'h7; E_ifun = 4'h4;
    tick();
    nop_all(); D_icode = 4'h9;
    tick(); D_icode = 4'h1;
    tick(); tick(); tick();
    chk("perf_luse", perf_luse, 32'd2);
    chk("perf_mispred", perf_mispred, 32'd1);
    chk("perf_ret", perf_ret, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control and condition-code unit for the pipelined Y86-64 core. It owns the architectural condition codes (ZF, SF, OF) and evaluates branch/cmov conditions for the execute stage. It detects load/use, mispredict and `ret` hazards and issues stall/bubble controls to the F, D, E, M and W pipeline registers. A small FSM sequences `ret` bubbles and latches the halted state on exceptions.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `D_icode`  in  4  icode in D register
- `d_srcA`, `d_srcB`  in  4 each  decode source register IDs; 4'hF = RNONE
- `E_icode`, `E_ifun`  in  4 each  icode/ifun in E register
- `E_dstM`  in  4  memory destination in E register
- `e_zf`, `e_sf`, `e_of`  in  1 each  flags from ALU result this cycle
- `m_stat`, `W_stat`  in  3 each  status codes: AOK=1, HLT=2, ADR=3, INS=4
- `e_cnd`  out  1  condition result for E instruction
- `cc`  out  3  registered {ZF,SF,OF}
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each  pipeline register controls
- `halted`  out  1  sticky halt indicator

## Operation
- FSM states: RUN, RET1, RET2, HALT. Register `cc` is 3 bits.
- Hazard terms, all combinational from inputs and state:
  - load_use: E_icode ∈ {5 mrmovq, B popq}, E_dstM ≠ F, and E_dstM == d_srcA or d_srcB.
  - mispred: E_icode == 7 and !e_cnd.
  - ret_d: D_icode == 9 in RUN.
- Priority in RUN:
  - load_use → F_stall=D_stall=E_bubble=1, D_bubble=0. Ret in D is held; no transition.
  - Else mispred → D_bubble=E_bubble=1. Ret in D is squashed; no transition.
  - Else ret_d → F_stall=D_bubble=1, next state RET1.
- RET1: F_stall=D_bubble=1, next state RET2. RET2: F_stall=D_bubble=1, next state RUN. Load_use and mispred cannot arise in RET1/RET2 because D holds bubbles. Their terms are still evaluated and OR'd into the outputs.
- Condition evaluation applies when E_icode ∈ {2,7}; otherwise e_cnd=0. Conditions by ifun:
  - 0: 1
  - 1: (SF^OF)|ZF
  - 2: SF^OF
  - 3: ZF
  - 4: !ZF
  - 5: !(SF^OF)
  - 6: !(SF^OF)&!ZF
  - 7–F: 0
- CC update: when E_icode == 6, m_stat == AOK and W_stat == AOK, `cc` ← {e_zf,e_sf,e_of} at the edge. Otherwise `cc` holds.
- Exceptions:
  - m_stat ≠ AOK → M_bubble=1.
  - W_stat ≠ AOK → W_stall=1 and next state HALT from any state.
- HALT: F_stall=D_stall=W_stall=1, E_bubble=M_bubble=1, `cc` frozen, `halted`=1. Only reset exits HALT.

## Timing
- Reset values: state RUN, cc=3'b100 (ZF=1), halted=0.
- While reset is asserted, all stall/bubble outputs are 0 and e_cnd follows the reset `cc`.
- Reset takes priority over every transition, including mid-RET1/RET2 and HALT.
- Control outputs are combinational, zero-latency, same cycle as inputs.
- `cc` is visible to e_cnd one cycle after the OPq that set it. This is back-to-back safe: OPq in M, jXX in E uses updated cc.
- `ret` produces exactly 3 cycles of F_stall/D_bubble: D, RET1, RET2.
- `halted` rises on the edge after W_stat ≠ AOK is first seen.
- Exception with simultaneous OPq in E: no CC write that cycle.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds three outputs, each 32 bits, reset to 0, wrap on overflow, frozen in HALT:
  - `perf_luse`: cycles with load_use.
  - `perf_mispred`: cycles with mispred.
  - `perf_ret`: entries into RET1.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- **Reset:** reset=1 for 2 cycles, then D/E at NOP → cc=3'b100, all controls 0, halted=0, state RUN.
- **Load/use:** E_icode=5, E_dstM=3, d_srcA=3 → F_stall=D_stall=E_bubble=1, D_bubble=0. With d_srcA=F and d_srcB=4 → all 0.
- **Mispredict:**
  - Set cc via E_icode=6 with e_zf=0, e_sf=1, e_of=0.
  - Next cycle E_icode=7, E_ifun=3 → e_cnd=0, D_bubble=E_bubble=1.
  - E_ifun=2 → e_cnd=1, no bubbles.
- **Ret:**
  - D_icode=9 for 1 cycle, then NOP → F_stall=D_bubble=1 for exactly 3 consecutive cycles, then 0.
  - With load_use coincident on the first cycle → ret sequence starts one cycle later.
- **Exception:**
  - E_icode=6 with m_stat=3 → cc unchanged, M_bubble=1.
  - W_stat=2 → next cycle halted=1 and all stalls asserted; remains until reset=1.
- **Perf (PIPE_CTRL_PERF_EN):** two load_use cycles, one mispredict and one ret → perf_luse=2, perf_mispred=1, perf_ret=1.
